// File: rtl/core_types_pkg.sv
// Shared dispatch-unit types: physical register tags, ROB indices and the
// ALU reservation station entry layout.
package core_types_pkg;

    localparam int PHYS_REG_TAG_W             = 6;
    localparam int ROB_INDEX_W                = 6;
    localparam int ALU_RS_NUM_ENTRIES_DEFAULT = 4;

    typedef logic [PHYS_REG_TAG_W-1:0] phys_reg_tag_t;
    typedef logic [ROB_INDEX_W-1:0]    rob_index_t;

    typedef struct packed {
        logic          valid;
        logic [3:0]    op;
        logic [15:0]   imm;
        phys_reg_tag_t source_0_tag;
        phys_reg_tag_t source_1_tag;
        logic          source_0_ready;
        logic          source_1_ready;
        phys_reg_tag_t dest_tag;
        rob_index_t    rob_index;
    } alu_rs_entry_t;

    // True when any valid complete bus broadcasts this tag.
    function automatic logic tag_hit(
        input phys_reg_tag_t tag,
        input logic [2:0]    bus_valid,
        input phys_reg_tag_t bus_0_tag,
        input phys_reg_tag_t bus_1_tag,
        input phys_reg_tag_t bus_2_tag
    );
        return (bus_valid[0] && bus_0_tag == tag) ||
               (bus_valid[1] && bus_1_tag == tag) ||
               (bus_valid[2] && bus_2_tag == tag);
    endfunction

endpackage

// File: rtl/alu_rs_oldest_ready_select.sv
// Priority encoder: reports whether any bit of ready_vec is set and the
// lowest set index (slot 0 is the oldest entry).
module alu_rs_oldest_ready_select #(
    parameter int NUM_ENTRIES = 4,
    parameter int IDX_W       = $clog2(NUM_ENTRIES)
) (
    input  logic [NUM_ENTRIES-1:0] ready_vec,
    output logic                   found,
    output logic [IDX_W-1:0]       index
);

    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    always_comb begin
        found = 1'b0;
        index = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (ready_vec[i]) begin
                found = 1'b1;
                index = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/alu_reservation_station.sv
// Age-ordered ALU reservation station with complete-bus wakeup and oldest-ready issue.
// Optional macro ALU_RS_SAME_CYCLE_WAKEUP_EN lets select see this cycle's bus matches.
module alu_reservation_station
    import core_types_pkg::*;
#(
    parameter int ALU_RS_NUM_ENTRIES = ALU_RS_NUM_ENTRIES_DEFAULT
) (
    input  logic          CLK,
    input  logic          nRST,
    output logic          DUT_error,
    input  logic          dispatch_valid,
    output logic          dispatch_ready,
    input  logic [3:0]    dispatch_op,
    input  logic [15:0]   dispatch_imm,
    input  phys_reg_tag_t dispatch_source_0_phys_reg_tag,
    input  logic          dispatch_source_0_ready,
    input  phys_reg_tag_t dispatch_source_1_phys_reg_tag,
    input  logic          dispatch_source_1_ready,
    input  phys_reg_tag_t dispatch_dest_phys_reg_tag,
    input  rob_index_t    dispatch_rob_index,
    input  logic          complete_bus_0_valid,
    input  phys_reg_tag_t complete_bus_0_dest_phys_reg_tag,
    input  logic          complete_bus_1_valid,
    input  phys_reg_tag_t complete_bus_1_dest_phys_reg_tag,
    input  logic          complete_bus_2_valid,
    input  phys_reg_tag_t complete_bus_2_dest_phys_reg_tag,
    output logic          issue_valid,
    input  logic          issue_ready,
    output logic [3:0]    issue_op,
    output logic [15:0]   issue_imm,
    output phys_reg_tag_t issue_source_0_phys_reg_tag,
    output phys_reg_tag_t issue_source_1_phys_reg_tag,
    output phys_reg_tag_t issue_dest_phys_reg_tag,
    output rob_index_t    issue_rob_index,
    input  logic          flush
);

    localparam int N     = ALU_RS_NUM_ENTRIES;
    localparam int IDX_W = $clog2(N);
    localparam int CNT_W = $clog2(N + 1);

    alu_rs_entry_t entries      [N];
    alu_rs_entry_t entries_next [N];
    alu_rs_entry_t entries_ext  [N+1];
    logic [CNT_W-1:0] count, count_next, count_after_issue;
    logic             error_next;

    logic [N-1:0]     ready_vec;
    logic             sel_found;
    logic [IDX_W-1:0] sel_idx;
    logic             issue_fire, dispatch_fire;
    logic [2:0]       bus_valid;
    alu_rs_entry_t    new_entry, shifted;

    assign bus_valid      = {complete_bus_2_valid, complete_bus_1_valid, complete_bus_0_valid};
    assign dispatch_ready = count < CNT_W'(N);
    assign dispatch_fire  = dispatch_valid & dispatch_ready;
    assign issue_valid    = sel_found;
    assign issue_fire     = sel_found & issue_ready;

    always_comb begin
        ready_vec = '0;
        for (int i = 0; i < N; i++) begin
`ifdef ALU_RS_SAME_CYCLE_WAKEUP_EN
            ready_vec[i] = entries[i].valid &
                (entries[i].source_0_ready | tag_hit(entries[i].source_0_tag, bus_valid,
                    complete_bus_0_dest_phys_reg_tag, complete_bus_1_dest_phys_reg_tag,
                    complete_bus_2_dest_phys_reg_tag)) &
                (entries[i].source_1_ready | tag_hit(entries[i].source_1_tag, bus_valid,
                    complete_bus_0_dest_phys_reg_tag, complete_bus_1_dest_phys_reg_tag,
                    complete_bus_2_dest_phys_reg_tag));
`else
            ready_vec[i] = entries[i].valid & entries[i].source_0_ready & entries[i].source_1_ready;
`endif
        end
    end

    alu_rs_oldest_ready_select #(
        .NUM_ENTRIES (N),
        .IDX_W       (IDX_W)
    ) u_select (
        .ready_vec (ready_vec),
        .found     (sel_found),
        .index     (sel_idx)
    );

    // Payload is zero whenever nothing is presented.
    always_comb begin
        issue_op                    = '0;
        issue_imm                   = '0;
        issue_source_0_phys_reg_tag = '0;
        issue_source_1_phys_reg_tag = '0;
        issue_dest_phys_reg_tag     = '0;
        issue_rob_index             = '0;
        for (int i = 0; i < N; i++) begin
            if (sel_found && IDX_W'(i) == sel_idx) begin
                issue_op                    = entries[i].op;
                issue_imm                   = entries[i].imm;
                issue_source_0_phys_reg_tag = entries[i].source_0_tag;
                issue_source_1_phys_reg_tag = entries[i].source_1_tag;
                issue_dest_phys_reg_tag     = entries[i].dest_tag;
                issue_rob_index             = entries[i].rob_index;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) entries_ext[i] = entries[i];
        entries_ext[N] = '0;

        new_entry                = '0;
        new_entry.valid          = 1'b1;
        new_entry.op             = dispatch_op;
        new_entry.imm            = dispatch_imm;
        new_entry.source_0_tag   = dispatch_source_0_phys_reg_tag;
        new_entry.source_1_tag   = dispatch_source_1_phys_reg_tag;
        new_entry.dest_tag       = dispatch_dest_phys_reg_tag;
        new_entry.rob_index      = dispatch_rob_index;
        new_entry.source_0_ready = dispatch_source_0_ready | tag_hit(dispatch_source_0_phys_reg_tag,
            bus_valid, complete_bus_0_dest_phys_reg_tag, complete_bus_1_dest_phys_reg_tag,
            complete_bus_2_dest_phys_reg_tag);
        new_entry.source_1_ready = dispatch_source_1_ready | tag_hit(dispatch_source_1_phys_reg_tag,
            bus_valid, complete_bus_0_dest_phys_reg_tag, complete_bus_1_dest_phys_reg_tag,
            complete_bus_2_dest_phys_reg_tag);

        count_after_issue = count - CNT_W'(issue_fire);
        count_next        = count_after_issue + CNT_W'(dispatch_fire);
        shifted           = '0;

        // Compact over the issued slot, then apply wakeup to the (possibly shifted) copy.
        for (int i = 0; i < N; i++) begin
            shifted = (issue_fire && i >= int'(sel_idx)) ? entries_ext[i+1] : entries_ext[i];
            shifted.source_0_ready = shifted.source_0_ready | tag_hit(shifted.source_0_tag,
                bus_valid, complete_bus_0_dest_phys_reg_tag, complete_bus_1_dest_phys_reg_tag,
                complete_bus_2_dest_phys_reg_tag);
            shifted.source_1_ready = shifted.source_1_ready | tag_hit(shifted.source_1_tag,
                bus_valid, complete_bus_0_dest_phys_reg_tag, complete_bus_1_dest_phys_reg_tag,
                complete_bus_2_dest_phys_reg_tag);
            entries_next[i] = shifted;
            if (dispatch_fire && CNT_W'(i) == count_after_issue) entries_next[i] = new_entry;
        end

        error_next = (dispatch_valid & ~dispatch_ready & ~flush) | (issue_fire & (count == '0));

        if (flush) begin
            for (int i = 0; i < N; i++) entries_next[i].valid = 1'b0;
            count_next = '0;
        end
    end

    // NOTE: the entry array is small and its contents drive issue payload, so it is
    // reset in full; a non-reset storage array would leave X on the outputs.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < N; i++) entries[i] <= '0;
            count     <= '0;
            DUT_error <= 1'b0;
        end else begin
            for (int i = 0; i < N; i++) entries[i] <= entries_next[i];
            count     <= count_next;
            DUT_error <= error_next;
        end
    end

endmodule

// File: tb/tb_alu_reservation_station.sv
// Directed bench for alu_reservation_station: expected issues go to a scoreboard
// queue and a negedge monitor pops and compares each accepted issue.
module tb_alu_reservation_station;
    import core_types_pkg::*;

`ifdef ALU_RS_SAME_CYCLE_WAKEUP_EN
    localparam logic SAME = 1'b1;
`else
    localparam logic SAME = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          nRST;
    logic          DUT_error;
    logic          dispatch_valid, dispatch_ready;
    logic [3:0]    dispatch_op;
    logic [15:0]   dispatch_imm;
    phys_reg_tag_t dispatch_source_0_phys_reg_tag, dispatch_source_1_phys_reg_tag;
    logic          dispatch_source_0_ready, dispatch_source_1_ready;
    phys_reg_tag_t dispatch_dest_phys_reg_tag;
    rob_index_t    dispatch_rob_index;
    logic          complete_bus_0_valid, complete_bus_1_valid, complete_bus_2_valid;
    phys_reg_tag_t complete_bus_0_dest_phys_reg_tag, complete_bus_1_dest_phys_reg_tag;
    phys_reg_tag_t complete_bus_2_dest_phys_reg_tag;
    logic          issue_valid, issue_ready;
    logic [3:0]    issue_op;
    logic [15:0]   issue_imm;
    phys_reg_tag_t issue_source_0_phys_reg_tag, issue_source_1_phys_reg_tag;
    phys_reg_tag_t issue_dest_phys_reg_tag;
    rob_index_t    issue_rob_index;
    logic          flush;

    typedef struct {
        logic [3:0]    op;
        logic [15:0]   imm;
        phys_reg_tag_t t0, t1, dest;
        rob_index_t    rob;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    alu_reservation_station dut (
        .CLK(CLK), .nRST(nRST), .DUT_error(DUT_error),
        .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
        .dispatch_op(dispatch_op), .dispatch_imm(dispatch_imm),
        .dispatch_source_0_phys_reg_tag(dispatch_source_0_phys_reg_tag),
        .dispatch_source_0_ready(dispatch_source_0_ready),
        .dispatch_source_1_phys_reg_tag(dispatch_source_1_phys_reg_tag),
        .dispatch_source_1_ready(dispatch_source_1_ready),
        .dispatch_dest_phys_reg_tag(dispatch_dest_phys_reg_tag),
        .dispatch_rob_index(dispatch_rob_index),
        .complete_bus_0_valid(complete_bus_0_valid),
        .complete_bus_0_dest_phys_reg_tag(complete_bus_0_dest_phys_reg_tag),
        .complete_bus_1_valid(complete_bus_1_valid),
        .complete_bus_1_dest_phys_reg_tag(complete_bus_1_dest_phys_reg_tag),
        .complete_bus_2_valid(complete_bus_2_valid),
        .complete_bus_2_dest_phys_reg_tag(complete_bus_2_dest_phys_reg_tag),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_op(issue_op), .issue_imm(issue_imm),
        .issue_source_0_phys_reg_tag(issue_source_0_phys_reg_tag),
        .issue_source_1_phys_reg_tag(issue_source_1_phys_reg_tag),
        .issue_dest_phys_reg_tag(issue_dest_phys_reg_tag),
        .issue_rob_index(issue_rob_index),
        .flush(flush)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic dispatch(input logic [3:0] op, input logic [15:0] imm,
                            input phys_reg_tag_t t0, input logic r0,
                            input phys_reg_tag_t t1, input logic r1,
                            input phys_reg_tag_t dest, input rob_index_t rob);
        dispatch_valid                 = 1'b1;
        dispatch_op                    = op;
        dispatch_imm                   = imm;
        dispatch_source_0_phys_reg_tag = t0;
        dispatch_source_0_ready        = r0;
        dispatch_source_1_phys_reg_tag = t1;
        dispatch_source_1_ready        = r1;
        dispatch_dest_phys_reg_tag     = dest;
        dispatch_rob_index             = rob;
        step();
        dispatch_valid = 1'b0;
    endtask

    task automatic expect_issue(input logic [3:0] op, input logic [15:0] imm,
                                input phys_reg_tag_t t0, input phys_reg_tag_t t1,
                                input phys_reg_tag_t dest, input rob_index_t rob);
        exp_t e;
        e.op = op; e.imm = imm; e.t0 = t0; e.t1 = t1; e.dest = dest; e.rob = rob;
        sb.push_back(e);
    endtask

    // Monitor: every accepted, non-squashed issue must match the oldest expectation.
    always @(negedge CLK) begin
        if (nRST && issue_valid && issue_ready && !flush) begin
            if (sb.size() == 0) begin
                check("unexpected_issue_rob", 32'(issue_rob_index), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("issue_op",   32'(issue_op),                    32'(e.op));
                check("issue_imm",  32'(issue_imm),                   32'(e.imm));
                check("issue_src0", 32'(issue_source_0_phys_reg_tag), 32'(e.t0));
                check("issue_src1", 32'(issue_source_1_phys_reg_tag), 32'(e.t1));
                check("issue_dest", 32'(issue_dest_phys_reg_tag),     32'(e.dest));
                check("issue_rob",  32'(issue_rob_index),             32'(e.rob));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        nRST = 1'b0;
        dispatch_valid = 1'b0; dispatch_op = '0; dispatch_imm = '0;
        dispatch_source_0_phys_reg_tag = '0; dispatch_source_0_ready = 1'b0;
        dispatch_source_1_phys_reg_tag = '0; dispatch_source_1_ready = 1'b0;
        dispatch_dest_phys_reg_tag = '0; dispatch_rob_index = '0;
        complete_bus_0_valid = 1'b0; complete_bus_0_dest_phys_reg_tag = '0;
        complete_bus_1_valid = 1'b0; complete_bus_1_dest_phys_reg_tag = '0;
        complete_bus_2_valid = 1'b0; complete_bus_2_dest_phys_reg_tag = '0;
        issue_ready = 1'b0; flush = 1'b0;
        repeat (2) @(posedge CLK);
        #1 nRST = 1'b1;

        // Reset state
        check("rst_dispatch_ready", 32'(dispatch_ready), 32'd1);
        check("rst_issue_valid",    32'(issue_valid),    32'd0);
        check("rst_dut_error",      32'(DUT_error),      32'd0);
        check("rst_issue_imm",      32'(issue_imm),      32'd0);
        check("rst_issue_rob",      32'(issue_rob_index), 32'd0);

        // Both sources ready: issues the cycle after dispatch
        issue_ready = 1'b1;
        expect_issue(4'h3, 16'h1234, 6'd33, 6'd34, 6'd10, 6'd1);
        dispatch(4'h3, 16'h1234, 6'd33, 1'b1, 6'd34, 1'b1, 6'd10, 6'd1);
        check("t1_issue_valid", 32'(issue_valid), 32'd1);
        step();
        check("t1_issue_gone",  32'(issue_valid),    32'd0);
        check("t1_empty_ready", 32'(dispatch_ready), 32'd1);

        // Wakeup from complete bus 1
        expect_issue(4'h5, 16'h00A5, 6'd40, 6'd0, 6'd11, 6'd2);
        dispatch(4'h5, 16'h00A5, 6'd40, 1'b0, 6'd0, 1'b1, 6'd11, 6'd2);
        check("t2_waiting", 32'(issue_valid), 32'd0);
        step();
        complete_bus_1_valid = 1'b1; complete_bus_1_dest_phys_reg_tag = 6'd40;
        #1;
        check("t2_bus_cycle", 32'(issue_valid), 32'(SAME));
        step();
        complete_bus_1_valid = 1'b0;
        check("t2_after_bus", 32'(issue_valid), 32'(!SAME));
        step();
        check("t2_drained", 32'(issue_valid), 32'd0);

        // Fill with unready entries, overflow raises DUT_error
        issue_ready = 1'b0;
        expect_issue(4'h1, 16'h0101, 6'd1, 6'd0, 6'd21, 6'd11);
        dispatch(4'h1, 16'h0101, 6'd1, 1'b0, 6'd0, 1'b1, 6'd21, 6'd11);
        dispatch(4'h2, 16'h0202, 6'd2, 1'b0, 6'd0, 1'b1, 6'd22, 6'd12);
        dispatch(4'h3, 16'h0303, 6'd3, 1'b0, 6'd0, 1'b1, 6'd23, 6'd13);
        dispatch(4'h4, 16'h0404, 6'd4, 1'b0, 6'd0, 1'b1, 6'd24, 6'd14);
        check("t3_full",       32'(dispatch_ready), 32'd0);
        check("t3_none_ready", 32'(issue_valid),    32'd0);
        check("t3_no_error",   32'(DUT_error),      32'd0);
        dispatch(4'h9, 16'h0909, 6'd9, 1'b1, 6'd9, 1'b1, 6'd29, 6'd19);
        check("t3_overflow_error", 32'(DUT_error), 32'd1);
        step();
        check("t3_error_clears", 32'(DUT_error), 32'd0);
        complete_bus_0_valid = 1'b1; complete_bus_0_dest_phys_reg_tag = 6'd1;
        step();
        complete_bus_0_valid = 1'b0;
        issue_ready = 1'b1;
        #1;
        check("t3_oldest_ready",    32'(issue_valid),    32'd1);
        check("t3_full_while_issue", 32'(dispatch_ready), 32'd0);
        step();
        issue_ready = 1'b0;
        check("t3_space_after_issue", 32'(dispatch_ready), 32'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("t3_flushed", 32'(issue_valid), 32'd0);

        // Out-of-order readiness: slot 0 and slot 2 ready, slot 1 waiting
        expect_issue(4'h6, 16'h0600, 6'd5, 6'd6, 6'd30, 6'd20);
        expect_issue(4'h8, 16'h0800, 6'd7, 6'd8, 6'd32, 6'd22);
        expect_issue(4'h7, 16'h0700, 6'd45, 6'd0, 6'd31, 6'd21);
        dispatch(4'h6, 16'h0600, 6'd5, 1'b1, 6'd6, 1'b1, 6'd30, 6'd20);
        dispatch(4'h7, 16'h0700, 6'd45, 1'b0, 6'd0, 1'b1, 6'd31, 6'd21);
        dispatch(4'h8, 16'h0800, 6'd7, 1'b1, 6'd8, 1'b1, 6'd32, 6'd22);
        issue_ready = 1'b1;
        step();
        step();
        check("t4_waiting_only", 32'(issue_valid), 32'd0);
        complete_bus_2_valid = 1'b1; complete_bus_2_dest_phys_reg_tag = 6'd45;
        step();
        complete_bus_2_valid = 1'b0;
        step();
        check("t4_drained",       32'(issue_valid),    32'd0);
        check("t4_ready_to_take", 32'(dispatch_ready), 32'd1);

        // Dispatch-time capture of a same-cycle complete
        expect_issue(4'hA, 16'hBEEF, 6'd50, 6'd0, 6'd33, 6'd23);
        complete_bus_2_valid = 1'b1; complete_bus_2_dest_phys_reg_tag = 6'd50;
        dispatch(4'hA, 16'hBEEF, 6'd50, 1'b0, 6'd0, 1'b1, 6'd33, 6'd23);
        complete_bus_2_valid = 1'b0;
        check("t5_captured_ready", 32'(issue_valid), 32'd1);
        step();
        check("t5_drained", 32'(issue_valid), 32'd0);

        // Flush with three entries; dispatch during flush is discarded
        issue_ready = 1'b0;
        dispatch(4'hB, 16'h0B0B, 6'd12, 1'b1, 6'd13, 1'b1, 6'd34, 6'd24);
        dispatch(4'hC, 16'h0C0C, 6'd14, 1'b0, 6'd15, 1'b1, 6'd35, 6'd25);
        dispatch(4'hD, 16'h0D0D, 6'd16, 1'b0, 6'd17, 1'b0, 6'd36, 6'd26);
        check("t6_pre_flush_valid", 32'(issue_valid), 32'd1);
        flush = 1'b1;
        dispatch(4'hE, 16'h0E0E, 6'd18, 1'b1, 6'd19, 1'b1, 6'd37, 6'd27);
        flush = 1'b0;
        check("t6_flush_issue_valid",    32'(issue_valid),    32'd0);
        check("t6_flush_dispatch_ready", 32'(dispatch_ready), 32'd1);
        check("t6_flush_no_error",       32'(DUT_error),      32'd0);
        step();
        check("t6_flush_dispatch_dropped", 32'(issue_valid), 32'd0);

        step();
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_reservation_station.md
# alu_reservation_station

Age-ordered issue buffer for ALU instructions, sitting in the dispatch unit directly downstream of the physical register ready table. It accepts dispatched ALU ops with their source tags and the ready bits the table provides, snoops the three complete buses to wake waiting sources, and issues the oldest fully-ready entry to the ALU pipeline through a valid/ready handshake.

## Interface
- ALU_RS_NUM_ENTRIES, 4, entry count (≥2; power of 2 not required)
- CLK  in  1  clock
- nRST  in  1  reset, asynchronous, active-low
- DUT_error  out  1  registered protocol-violation flag
- dispatch_valid  in  1  dispatch offers an op
- dispatch_ready  out  1  RS can accept (not full)
- dispatch_op  in  4  ALU opcode, opaque payload
- dispatch_imm  in  16  immediate, opaque payload
- dispatch_source_0_phys_reg_tag / dispatch_source_1_phys_reg_tag  in  phys_reg_tag_t  source tags
- dispatch_source_0_ready / dispatch_source_1_ready  in  1  ready bits from ready table (already write-forwarded)
- dispatch_dest_phys_reg_tag  in  phys_reg_tag_t  destination tag
- dispatch_rob_index  in  rob_index_t  ROB slot
- complete_bus_{0,1,2}_valid  in  1  complete bus valid
- complete_bus_{0,1,2}_dest_phys_reg_tag  in  phys_reg_tag_t  completing tag
- issue_valid  out  1  oldest ready entry presented
- issue_ready  in  1  ALU pipeline accepts
- issue_op, issue_imm, issue_source_0/1_phys_reg_tag, issue_dest_phys_reg_tag, issue_rob_index  out  as dispatch  issued payload
- flush  in  1  squash all entries

## Operation
- Entries held compacted in age order: slot 0 oldest, slots [0, count-1] valid. Per entry: valid, payload, two source tags, two ready bits.
- Dispatch accepted when dispatch_valid & dispatch_ready. Written into slot count (slot count-1 if an issue fires the same cycle). Ready bits stored = dispatch ready input OR match against any valid complete bus this cycle.
- Wakeup: each valid entry source with tag equal to any valid complete bus tag sets its ready bit at the next edge. Tag 0 always ready by construction (the table marks it ready); no special case.
- Select: issue_valid = some valid entry with both ready bits set; issue outputs carry the lowest-indexed such entry. Outputs are combinational from entry state (plus bypass, see Configuration).
- Issue fires on issue_valid & issue_ready: that entry is removed, all younger entries shift down one slot in the same edge, wakeup applied to the shifted copies.
- dispatch_ready = count < ALU_RS_NUM_ENTRIES (registered count; a same-cycle issue does not free space for that cycle's dispatch).
- flush: all valid bits cleared next edge; dispatch and issue in the flush cycle are discarded; issue_valid still combinationally reflects pre-flush state, so the consumer treats issue during flush as squashed.
- DUT_error next = dispatch_valid & ~dispatch_ready & ~flush, or an issue fire while no entry is valid.

## Timing
- Reset: all entries invalid, count 0, dispatch_ready 1, issue_valid 0, issue payload outputs 0, DUT_error 0.
- Dispatch at edge N with both sources ready -> issue_valid from cycle N+1.
- Complete bus tag in cycle N -> dependent entry issuable in cycle N+1 (N with bypass).
- Full: dispatch_ready 0 until the cycle after the first issue.
- Simultaneous dispatch + issue + wakeup on same tag all resolve in one edge; no ordering hazard.
- Reset mid-operation: entries discarded immediately (asynchronous).

## Configuration
- ALU_RS_SAME_CYCLE_WAKEUP_EN defined: select logic ORs each existing entry's stored ready bits with the current cycle's complete-bus tag matches, enabling back-to-back dependent issue (N). Newly dispatched entries still wait one cycle.
- Undefined: select uses stored ready bits only; dependent issue one cycle after complete (N+1).

## Structure
- core_types_pkg: phys_reg_tag_t, rob_index_t, ALU_RS_NUM_ENTRIES default, alu_rs_entry_t struct (valid, op, imm, tags, ready bits, rob index).
- One sub-module: alu_rs_oldest_ready_select, a priority encoder returning found flag and lowest index of a ready-vector.

## Test plan
- Reset, dispatch op with tags 33/34 both ready, issue_ready 1 -> issue_valid next cycle with those tags; count returns to 0.
- Dispatch source 0 tag 40 not ready; complete_bus_1 tag 40 two cycles later -> issue next cycle (same cycle with macro).
- Fill 4 entries with none ready -> dispatch_ready 0; extra dispatch_valid -> DUT_error 1 one cycle later.
- Entries 0 and 2 ready, 1 waiting -> entry 0 issues, then entry 2 (now slot 1), order of remaining preserved.
- Dispatch with tag 50 while complete_bus_2 carries 50 same cycle -> entry stored ready, issues next cycle.
- Three entries valid, flush asserted -> all invalid next cycle, dispatch_ready 1, issue_valid 0.
